data_cache_ctrl: RTL and testbench
==================================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width.
REQ-002 SHALL have parameter WORD_W, default 32, meaning data word width.
REQ-003 SHALL have parameter LINES, default 16 (power of two), meaning direct-mapped one-word lines.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset; synchronous, active-high.
- cpu_addr  in  ADDR_W  byte address from the MEM stage.
- cpu_req  in  1  request valid.
- cpu_rw  in  1  1=write, 0=read.
- cpu_wdata  in  WORD_W  store data.
- cpu_byte_en  in  WORD_W/8  store byte lanes.
- cpu_rdata  out  WORD_W  load data.
- cpu_ready  out  1  request completed this cycle.
- mem_req  out  1  DRAM request valid.
- mem_we  out  1  DRAM write.
- mem_addr  out  ADDR_W  DRAM word-aligned address.
- mem_wdata  out  WORD_W  DRAM write data.
- mem_byte_en  out  WORD_W/8  DRAM write lanes.
- mem_rdata  in  WORD_W  DRAM read data.
- mem_ack  in  1  DRAM completion, one-cycle pulse.

Function
REQ-005 SHALL split cpu_addr into offset [1:0] (ignored), index [log2(LINES)+1:2], tag = remaining upper bits.
REQ-006 SHALL hold per line a valid bit, tag, and WORD_W data.
REQ-007 SHALL implement FSM states IDLE, FILL, WRITE.
REQ-008 IDLE, cpu_req=1, cpu_rw=0, hit: cpu_ready=1 and cpu_rdata=line data combinationally in the same cycle; no state change.
REQ-009 IDLE, read miss: cpu_ready=0; next state FILL.
REQ-010 FILL: mem_req=1, mem_we=0, mem_addr={cpu_addr[ADDR_W-1:2],2'b00} until mem_ack; on mem_ack write mem_rdata, tag, valid=1 into line; return to IDLE; the hit is served the following cycle (miss latency = DRAM latency + 1 cycle).
REQ-011 IDLE, cpu_req=1, cpu_rw=1: next state WRITE (write-through, no write-allocate).
REQ-012 WRITE: mem_req=1, mem_we=1, mem_addr word-aligned, mem_wdata=cpu_wdata, mem_byte_en=cpu_byte_en until mem_ack.
REQ-013 On mem_ack in WRITE: cpu_ready=1 that cycle; if line hits, update only bytes enabled in cpu_byte_en; miss leaves line unchanged; return to IDLE.
REQ-014 cpu_ready SHALL be 0 in FILL and in WRITE cycles without mem_ack; cpu_ready SHALL be 0 when cpu_req=0.
REQ-015 CPU SHALL hold cpu_addr/cpu_rw/cpu_wdata/cpu_byte_en stable while cpu_req=1 and cpu_ready=0; block captures nothing else.
REQ-016 mem_req SHALL be 0 in IDLE; mem_we, mem_byte_en SHALL be 0 when mem_req=0.
REQ-017 cpu_byte_en=0 write SHALL still perform a DRAM transaction and complete normally.
REQ-018 mem_ack while in IDLE SHALL be ignored.
REQ-019 cpu_rdata SHALL be 0 when cpu_ready=0 or on a write.

Reset
REQ-020 reset=1 SHALL clear all valid bits, force state IDLE, cpu_ready=0, mem_req=0, in one cycle.
REQ-021 reset mid-FILL or mid-WRITE SHALL abandon the transaction; a subsequent mem_ack is ignored; data arrays need not reset.

Verification
REQ-022 After reset, read 0x040 (DRAM word 0xDEADBEEF, ack after 3 cycles) -> mem_req 3 cycles, cpu_ready on cycle 5, cpu_rdata=0xDEADBEEF; repeat read -> cpu_ready same cycle, no mem_req.
REQ-023 Write 0x040, data 0x11223344, byte_en 4'b0011, after REQ-022 fill -> mem_we=1, mem_byte_en=0011; then read 0x040 hit -> 0xDEAD3344.
REQ-024 Write miss 0x080 then read 0x080 -> write causes no fill; read misses and issues FILL.
REQ-025 Conflict: fill 0x040 then read 0x440 (same index, different tag) -> miss, line replaced; read 0x040 misses again.
REQ-026 Assert reset during FILL, then ack arrives -> no line valid, cpu_ready stays 0, state IDLE.
REQ-027 cpu_req=0 for 10 cycles with stray mem_ack -> mem_req=0, cpu_ready=0 throughout.

Source files
------------

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One-word lines; read misses fill from DRAM, all stores go to DRAM.
module data_cache_ctrl #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32,
    parameter int LINES  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_req,
    input  logic                cpu_rw,
    input  logic [WORD_W-1:0]   cpu_wdata,
    input  logic [WORD_W/8-1:0] cpu_byte_en,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic [WORD_W/8-1:0] mem_byte_en,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;
    localparam int BE_W    = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t             state;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [WORD_W-1:0]  data_mem [LINES];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    assign index = cpu_addr[INDEX_W+1:2];
    assign tag   = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign hit   = valid[index] && (tag_mem[index] == tag);

    // Controller FSM; DRAM request/write strobes are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (cpu_rw) begin
                            state     <= WRITE;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b1;
                        end else if (!hit) begin
                            state     <= FILL;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[index] <= 1'b1;
                        state        <= IDLE;
                        mem_req_q    <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays: line fill on read-miss completion, byte merge on write hit
    always_ff @(posedge clk) begin
        if (!reset && mem_ack) begin
            if (state == FILL) begin
                tag_mem[index]  <= tag;
                data_mem[index] <= mem_rdata;
            end else if (state == WRITE && hit) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (cpu_byte_en[b]) begin
                        data_mem[index][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // CPU-side handshake: read hits answer in the same cycle, writes complete on DRAM ack
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        if (!reset && cpu_req) begin
            case (state)
                IDLE: begin
                    if (!cpu_rw && hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = data_mem[index];
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        cpu_ready = 1'b1;
                    end
                end
                default: begin
                    cpu_ready = 1'b0;
                end
            endcase
        end
    end

    // DRAM side: address is the held CPU address with the byte offset masked off
    always_comb begin
        mem_req     = mem_req_q;
        mem_we      = mem_we_q;
        mem_addr    = cpu_addr & ~ADDR_W'(3);
        mem_wdata   = mem_we_q ? cpu_wdata : '0;
        mem_byte_en = mem_we_q ? cpu_byte_en : '0;
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed, table-driven bench for data_cache_ctrl (default parameters).
module tb_data_cache_ctrl;

    logic        clk;
    logic        reset;
    logic [11:0] cpu_addr;
    logic        cpu_req;
    logic        cpu_rw;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_en;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    data_cache_ctrl #(
        .ADDR_W(12),
        .WORD_W(32),
        .LINES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_byte_en(cpu_byte_en),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byte_en(mem_byte_en),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        req;
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        ack;
        logic [31:0] mrd;
        logic        e_ready;
        logic [31:0] e_rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [11:0] e_maddr;
        logic [3:0]  e_mbe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(string nm, logic req, logic rw, logic [11:0] addr,
                                 logic [31:0] wd, logic [3:0] be, logic ack, logic [31:0] mrd,
                                 logic er, logic [31:0] erd, logic emr, logic emw,
                                 logic [11:0] ema, logic [3:0] emb);
        vec_t v;
        v.nm = nm; v.req = req; v.rw = rw; v.addr = addr; v.wd = wd; v.be = be;
        v.ack = ack; v.mrd = mrd; v.e_ready = er; v.e_rdata = erd; v.e_mreq = emr;
        v.e_mwe = emw; v.e_maddr = ema; v.e_mbe = emb;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset       = 1'b0;
        cpu_req     = v.req;
        cpu_rw      = v.rw;
        cpu_addr    = v.addr;
        cpu_wdata   = v.wd;
        cpu_byte_en = v.be;
        mem_ack     = v.ack;
        mem_rdata   = v.mrd;
    endtask

    task automatic compare(vec_t v);
        check({v.nm, ".cpu_ready"}, 32'(cpu_ready), 32'(v.e_ready));
        check({v.nm, ".cpu_rdata"}, cpu_rdata, v.e_rdata);
        check({v.nm, ".mem_req"}, 32'(mem_req), 32'(v.e_mreq));
        check({v.nm, ".mem_we"}, 32'(mem_we), 32'(v.e_mwe));
        check({v.nm, ".mem_byte_en"}, 32'(mem_byte_en), 32'(v.e_mbe));
        if (v.e_mreq) check({v.nm, ".mem_addr"}, 32'(mem_addr), 32'(v.e_maddr));
        if (v.e_mwe) check({v.nm, ".mem_wdata"}, mem_wdata, v.wd);
    endtask

    // One cycle: drive just after the rising edge, sample at the falling edge
    task automatic run_vec(vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        compare(v);
    endtask

    initial begin
        // name, req, rw, addr, wdata, be, ack, mem_rdata | ready, rdata, mreq, mwe, maddr, mbe
        tbl.push_back(mkv("idle_after_reset", 0, 0, 12'h000, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd040_miss",       1, 0, 12'h040, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("fill040_c1",       1, 0, 12'h040, 0, 4'h0, 0, 0,              0, 0,            1, 0, 12'h040, 4'h0));
        tbl.push_back(mkv("fill040_c2",       1, 0, 12'h040, 0, 4'h0, 0, 0,              0, 0,            1, 0, 12'h040, 4'h0));
        tbl.push_back(mkv("fill040_ack",      1, 0, 12'h040, 0, 4'h0, 1, 32'hDEADBEEF,   0, 0,            1, 0, 12'h040, 4'h0));
        tbl.push_back(mkv("rd040_hit",        1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEADBEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd040_rehit",      1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEADBEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr040_issue",      1, 1, 12'h040, 32'h11223344, 4'h3, 0, 0,   0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr040_wait",       1, 1, 12'h040, 32'h11223344, 4'h3, 0, 0,   0, 0,            1, 1, 12'h040, 4'h3));
        tbl.push_back(mkv("wr040_ack",        1, 1, 12'h040, 32'h11223344, 4'h3, 1, 0,   1, 0,            1, 1, 12'h040, 4'h3));
        tbl.push_back(mkv("rd040_merged",     1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEAD3344, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr080_issue",      1, 1, 12'h080, 32'hAABBCCDD, 4'hF, 0, 0,   0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr080_ack",        1, 1, 12'h080, 32'hAABBCCDD, 4'hF, 1, 0,   1, 0,            1, 1, 12'h080, 4'hF));
        tbl.push_back(mkv("rd080_miss",       1, 0, 12'h080, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("fill080_ack",      1, 0, 12'h080, 0, 4'h0, 1, 32'h55667788,   0, 0,            1, 0, 12'h080, 4'h0));
        tbl.push_back(mkv("rd080_hit",        1, 0, 12'h080, 0, 4'h0, 0, 0,              1, 32'h55667788, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd040_miss2",      1, 0, 12'h040, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("fill040_ack2",     1, 0, 12'h040, 0, 4'h0, 1, 32'hDEADBEEF,   0, 0,            1, 0, 12'h040, 4'h0));
        tbl.push_back(mkv("rd040_hit2",       1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEADBEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd440_conflict",   1, 0, 12'h440, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("fill440_ack",      1, 0, 12'h440, 0, 4'h0, 1, 32'h44004400,   0, 0,            1, 0, 12'h440, 4'h0));
        tbl.push_back(mkv("rd440_hit",        1, 0, 12'h440, 0, 4'h0, 0, 0,              1, 32'h44004400, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd040_evicted",    1, 0, 12'h040, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("fill040_ack3",     1, 0, 12'h040, 0, 4'h0, 1, 32'hDEADBEEF,   0, 0,            1, 0, 12'h040, 4'h0));
        tbl.push_back(mkv("rd040_hit3",       1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEADBEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr_be0_issue",     1, 1, 12'h040, 32'hFFFFFFFF, 4'h0, 0, 0,   0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr_be0_wait",      1, 1, 12'h040, 32'hFFFFFFFF, 4'h0, 0, 0,   0, 0,            1, 1, 12'h040, 4'h0));
        tbl.push_back(mkv("wr_be0_ack",       1, 1, 12'h040, 32'hFFFFFFFF, 4'h0, 1, 0,   1, 0,            1, 1, 12'h040, 4'h0));
        tbl.push_back(mkv("rd040_be0_same",   1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEADBEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("stray_ack_idle",   0, 0, 12'h040, 0, 4'h0, 1, 32'h12345678,   0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd040_post_stray", 1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hDEADBEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr_hi_issue",      1, 1, 12'h040, 32'hA1B2C3D4, 4'hC, 0, 0,   0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("wr_hi_ack",        1, 1, 12'h040, 32'hA1B2C3D4, 4'hC, 1, 0,   1, 0,            1, 1, 12'h040, 4'hC));
        tbl.push_back(mkv("rd040_hi_merged",  1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hA1B2BEEF, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd04b_miss",       1, 0, 12'h04B, 0, 4'h0, 0, 0,              0, 0,            0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("fill04b_aligned",  1, 0, 12'h04B, 0, 4'h0, 1, 32'hCAFEF00D,   0, 0,            1, 0, 12'h048, 4'h0));
        tbl.push_back(mkv("rd049_hit",        1, 0, 12'h049, 0, 4'h0, 0, 0,              1, 32'hCAFEF00D, 0, 0, 12'h000, 4'h0));
        tbl.push_back(mkv("rd040_index0_kept",1, 0, 12'h040, 0, 4'h0, 0, 0,              1, 32'hA1B2BEEF, 0, 0, 12'h000, 4'h0));

        reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_byte_en = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset in the middle of a fill: the late ack must be dropped and all lines invalid
        run_vec(mkv("rst_rd0c0_miss",   1, 0, 12'h0C0, 0, 4'h0, 0, 0,            0, 0,            0, 0, 12'h000, 4'h0));
        run_vec(mkv("rst_fill0c0",      1, 0, 12'h0C0, 0, 4'h0, 0, 0,            0, 0,            1, 0, 12'h0C0, 4'h0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_during_fill.cpu_ready", 32'(cpu_ready), 32'h0);
        run_vec(mkv("rst_late_ack",     0, 0, 12'h0C0, 0, 4'h0, 1, 32'h0BADBAD0, 0, 0,            0, 0, 12'h000, 4'h0));
        run_vec(mkv("rst_idle",         0, 0, 12'h000, 0, 4'h0, 0, 0,            0, 0,            0, 0, 12'h000, 4'h0));
        run_vec(mkv("rst_rd0c0_nohit",  1, 0, 12'h0C0, 0, 4'h0, 0, 0,            0, 0,            0, 0, 12'h000, 4'h0));
        run_vec(mkv("rst_fill0c0_ack",  1, 0, 12'h0C0, 0, 4'h0, 1, 32'h0C0C0C0C, 0, 0,            1, 0, 12'h0C0, 4'h0));
        run_vec(mkv("rst_rd0c0_hit",    1, 0, 12'h0C0, 0, 4'h0, 0, 0,            1, 32'h0C0C0C0C, 0, 0, 12'h000, 4'h0));
        run_vec(mkv("rst_rd048_inval",  1, 0, 12'h048, 0, 4'h0, 0, 0,            0, 0,            0, 0, 12'h000, 4'h0));
        run_vec(mkv("rst_fill048_ack",  1, 0, 12'h048, 0, 4'h0, 1, 32'h48484848, 0, 0,            1, 0, 12'h048, 4'h0));
        run_vec(mkv("rst_rd048_hit",    1, 0, 12'h048, 0, 4'h0, 0, 0,            1, 32'h48484848, 0, 0, 12'h000, 4'h0));

        // Ten idle cycles with stray DRAM acks: nothing may be issued or completed
        for (int i = 0; i < 10; i++) begin
            run_vec(mkv($sformatf("quiet_%0d", i), 0, 0, 12'h040, 32'hFFFFFFFF, 4'hF,
                        ((i % 3) == 0), 32'h99999999, 0, 0, 0, 0, 12'h000, 4'h0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
